// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Operation encoding matches the EX-stage shift decode.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  localparam int OP_W = 2;

endpackage

// File: rtl/shift_stage.sv
// One level of the pipelined barrel shifter: conditional shift by a fixed
// power-of-two distance followed by an elastic payload register.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int SHW   = $clog2(WIDTH),
  parameter int LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  shift_op_e        in_op,
  input  logic             in_fill,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output shift_op_e        out_op,
  output logic             out_fill,
  output logic [TAG_W-1:0] out_tag
);

  localparam int DIST = 1 << LEVEL;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    shift_op_e        op;
    logic             fill;
    logic [TAG_W-1:0] tag;
  } payload_t;

  payload_t         payload;
  logic [WIDTH-1:0] shifted;
  logic             load;

  // A stage may load when empty or when its contents leave this cycle.
  assign load     = ~out_valid | out_ready;
  assign in_ready = ~flush & load;

  // Conditional shift for this level's shift-amount bit.
  always_comb begin
    shifted = in_data;
    if (in_shamt[LEVEL]) begin
      case (in_op)
        OP_SLL:  shifted = in_data << DIST;
        OP_SRL:  shifted = in_data >> DIST;
        OP_SRA:  shifted = {{DIST{in_fill}}, in_data[WIDTH-1:DIST]};
        OP_ROR:  shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
        default: shifted = in_data;
      endcase
    end else begin
      shifted = in_data;
    end
  end

  // Valid bit and payload register; a stalled stage holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      payload   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        payload <= '{data: shifted, shamt: in_shamt, op: in_op,
                     fill: in_fill, tag: in_tag};
      end
    end
  end

  assign out_data  = payload.data;
  assign out_shamt = payload.shamt;
  assign out_op    = payload.op;
  assign out_fill  = payload.fill;
  assign out_tag   = payload.tag;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake,
// flush and a pass-through tag; one register rank per shift level.
module shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Index k is the input of stage k; index SHW is the last stage's register.
  logic             valid_c [0:SHW];
  logic             ready_c [0:SHW];
  logic [WIDTH-1:0] data_c  [0:SHW];
  logic [SHW-1:0]   shamt_c [0:SHW];
  shift_op_e        op_c    [0:SHW];
  logic             fill_c  [0:SHW];
  logic [TAG_W-1:0] tag_c   [0:SHW];

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign shamt_c[0] = in_shamt;
  assign op_c[0]    = shift_op_e'(in_op);
  assign fill_c[0]  = in_data[WIDTH-1];
  assign tag_c[0]   = in_tag;
  assign in_ready   = ready_c[0];

  assign ready_c[SHW] = out_ready;
  assign out_valid    = valid_c[SHW];
  assign out_data     = data_c[SHW];
  assign out_tag      = tag_c[SHW];

  // Largest shift distance first, so stage k handles shamt bit SHW-1-k.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH(WIDTH),
      .TAG_W(TAG_W),
      .SHW  (SHW),
      .LEVEL(SHW - 1 - k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (valid_c[k]),
      .in_ready (ready_c[k]),
      .in_data  (data_c[k]),
      .in_shamt (shamt_c[k]),
      .in_op    (op_c[k]),
      .in_fill  (fill_c[k]),
      .in_tag   (tag_c[k]),
      .out_valid(valid_c[k+1]),
      .out_ready(ready_c[k+1]),
      .out_data (data_c[k+1]),
      .out_shamt(shamt_c[k+1]),
      .out_op   (op_c[k+1]),
      .out_fill (fill_c[k+1]),
      .out_tag  (tag_c[k+1])
    );
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases, random streams,
// backpressure, flush and asynchronous reset against a behavioural model.
module tb_shift_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt, in_tag, out_tag;
  logic [1:0]  in_op;

  int   vectors = 0;
  int   miscompares = 0;
  int   n_out = 0;
  int   base;
  int   issued;
  bit   sb_en = 1'b0;
  bit   accepted = 1'b0;
  bit   last_in_ready = 1'b0;
  exp_t q[$];
  logic [31:0] rd;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  // Reference shifter written directly from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic [1:0] op);
    logic [63:0] dd;
    logic [63:0] rot;
    logic signed [31:0] sd;
    dd  = {d, d};
    rot = dd >> sh;
    sd  = $signed(d);
    case (op)
      2'd0:    return d << sh;
      2'd1:    return d >> sh;
      2'd2:    return 32'(sd >>> sh);
      default: return rot[31:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive_rand();
    in_data  = $urandom;
    in_shamt = 5'($urandom_range(0, 31));
    in_op    = 2'($urandom_range(0, 3));
    in_tag   = 5'($urandom_range(0, 31));
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    accepted      = 1'b0;
    last_in_ready = in_ready;
    if (flush) begin
      check("flush_blocks_input", 64'(in_ready), 64'd0);
      q.delete();
    end else begin
      if (sb_en && out_valid) begin
        check("out_expected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          check("out_data", 64'(out_data), 64'(q[0].data));
          check("out_tag", 64'(out_tag), 64'(q[0].tag));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e.data = ref_shift(in_data, in_shamt, in_op);
        e.tag  = in_tag;
        q.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                           input logic [4:0] tg, input logic [31:0] exp, input string name);
    int lat;
    lat       = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_op     = op;
    in_tag    = tg;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({name, "_latency"}, 64'(lat), 64'd5);
    check({name, "_data"}, 64'(out_data), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tg));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 32'd0;
    in_shamt  = 5'd0;
    in_op     = 2'd0;
    in_tag    = 5'd0;

    // Reset state
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed operations and boundaries
    single_op(32'h0000_0001, 5'd31, 2'b00, 5'd7, 32'h8000_0000, "sll31");
    single_op(32'h8000_0000, 5'd4, 2'b10, 5'd1, 32'hF800_0000, "sra4");
    single_op(32'h8000_0000, 5'd4, 2'b01, 5'd2, 32'h0800_0000, "srl4");
    single_op(32'h0000_00F1, 5'd4, 2'b11, 5'd3, 32'h1000_000F, "ror4");
    single_op(32'h8000_0001, 5'd31, 2'b11, 5'd4, 32'h0000_0003, "ror31");
    single_op(32'h8000_0000, 5'd31, 2'b10, 5'd5, 32'hFFFF_FFFF, "sra31");
    single_op(32'h7FFF_FFFF, 5'd31, 2'b10, 5'd6, 32'h0000_0000, "sra31_pos");
    for (int op = 0; op < 4; op++) begin
      rd = $urandom;
      single_op(rd, 5'd0, 2'(op), 5'(op + 8), rd, "shamt0");
    end

    // Back-to-back random stream
    sb_en     = 1'b1;
    out_ready = 1'b1;
    base      = n_out;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      drive_rand();
      cyc();
      check("stream_accept", 64'(accepted), 64'd1);
    end
    in_valid = 1'b0;
    repeat (5) cyc();
    check("stream_drained", 64'(q.size()), 64'd0);
    check("stream_count", 64'(n_out - base), 64'd20);

    // Backpressure: out_ready low for 8 cycles mid-stream
    base     = n_out;
    in_valid = 1'b1;
    drive_rand();
    issued = 1;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i < 6 || i >= 14);
      cyc();
      if (i == 13) check("stall_in_ready_low", 64'(last_in_ready), 64'd0);
      if (i == 14) check("resume_in_ready", 64'(last_in_ready), 64'd1);
      if (accepted) begin
        if (issued < 20) begin
          drive_rand();
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("bp_drained", 64'(q.size()), 64'd0);
    check("bp_count", 64'(n_out - base), 64'd20);

    // Flush with three ops in flight plus a flush-cycle op
    out_ready = 1'b1;
    base      = n_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive_rand();
      cyc();
      check("pre_flush_accept", 64'(accepted), 64'd1);
    end
    drive_rand();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive_rand();
    cyc();
    check("post_flush_accept", 64'(accepted), 64'd1);
    in_valid = 1'b0;
    repeat (10) cyc();
    check("flush_drained", 64'(q.size()), 64'd0);
    check("flush_count", 64'(n_out - base), 64'd1);

    // Asynchronous reset mid-clock with the pipe full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_rand();
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (accepted) drive_rand();
    end
    check("full_in_ready_low", 64'(last_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data", 64'(out_data), 64'd0);
    check("async_rst_out_tag", 64'(out_tag), 64'd0);
    q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    base = n_out;
    repeat (8) cyc();
    check("post_rst_no_output", 64'(n_out - base), 64'd0);
    sb_en = 1'b0;
    rd    = $urandom;
    single_op(rd, 5'd13, 2'b11, 5'd21, ref_shift(rd, 5'd13, 2'b11), "post_rst_op");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the MIPS pipelined CPU datapath. It generalises the single-cycle left/right logical shifter: the data width is parametrised, and it adds arithmetic right shift and rotate right. One register rank follows each shift level, with valid/ready handshaking on both sides, a flush input for branch/exception squash, and a tag carried alongside each operation for write-back routing. It sits in the EX stage as a multi-cycle functional unit.

## Interface
- WIDTH, 32: data width; power of two, 8..64.
- TAG_W, 5: width of the pass-through tag (destination register id).
- SHW, $clog2(WIDTH): derived localparam; shift-amount width and pipeline depth.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous squash of all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit accepts the input this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Pipeline of SHW stages. Stage k (k = 0..SHW-1) applies shift-amount bit SHW-1-k, i.e. a shift of 2^(SHW-1-k), largest shift first. It then registers data, remaining shamt bits, op, fill bit, tag and a valid bit.
- Per-level behaviour when its shamt bit = 1:
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with the sign bit. The sign bit is in_data[WIDTH-1], captured at acceptance and carried down the pipe.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- When the level's shamt bit = 0, data passes through unchanged.
- shamt = 0 gives the identity for all ops.
- Rotate-left is not supported. Issue ROR with shamt = (WIDTH - n) mod WIDTH.
- Elastic pipeline: stage k loads when stage k's valid = 0 or stage k+1 (or the output, for the last stage) takes its contents this cycle. Bubbles collapse; a stalled stage holds all of its fields.
- in_ready = !flush && (stage0 empty || stage0 advancing).
- Transfer occurs on in_valid && in_ready at the input and on out_valid && out_ready at the output.
- flush: at the next edge every stage valid clears and no input is accepted that cycle. Flush wins over a simultaneous in_valid or out_ready. Data registers need not clear.
- out_valid/out_data/out_tag are the last stage's registers. While out_valid && !out_ready, they must hold stable.

## Timing
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+SHW-1, so it is visible in the cycle following the SHW-th register load. For WIDTH=32 this is 5 register ranks, i.e. result at cycle t+5 relative to the cycle in_valid was sampled.
- Throughput: one operation per clock while out_ready = 1. No combinational path from in_valid to out_*.
- The only combinational path from out_ready is to in_ready, through the stage advance chain. This path is documented and accepted.
- Reset (asynchronous, rst_n = 0): all valid bits, out_valid, out_data and out_tag go to 0. in_ready = 1 in the first cycle after release. Reset mid-operation discards everything in flight.
- Full pipe with out_ready = 0: in_ready = 0 and all stages hold. When out_ready rises, all stages advance the same cycle and in_ready = 1.
- Order is strictly FIFO. Operations never reorder or duplicate.

## Structure
- Package shift_pkg:
  - shift_op_e enum {OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11}.
  - Per-stage payload struct (data, shamt, op, fill, tag), parametrised via the module's localparams.
- Sub-module shift_stage: one level, parametrised by WIDTH, TAG_W and the level's shift distance. It holds the combinational shift, the payload register and the valid/ready logic. shift_pipe instantiates SHW of them with a generate loop.

## Test plan
- Reset, then WIDTH=32, SLL of 32'h0000_0001 by 31, tag 5'd7 -> out_data 32'h8000_0000, out_tag 7, out_valid 5 cycles after acceptance.
- SRA of 32'h8000_0000 by 4 -> 32'hF800_0000; SRL of the same by 4 -> 32'h0800_0000; ROR of 32'h0000_00F1 by 4 -> 32'h1000_000F; any op with shamt 0 -> the input unchanged.
- Back-to-back stream of 20 random ops with out_ready=1 -> one result per cycle, in order, matching the reference model.
- Hold out_ready=0 for 8 cycles during the stream:
  - pipe fills and in_ready drops;
  - out_data/out_tag stay stable;
  - when out_ready rises, the stream resumes with no loss or duplication.
- Assert flush together with in_valid while 3 ops are in flight -> no outputs from those 3 or the flush-cycle op; the next op accepted produces the first result.
- Pulse rst_n low asynchronously, mid-clock, with the pipe full -> out_valid and out_data drop to 0 immediately; the pipe is empty after release.
